// File: rtl/stream_demux_pkg.sv
// demux_pkg: default parameters and width/index helpers shared by the stream demux
package demux_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_N_CH   = 4;
    localparam int DEF_CNT_W  = 8;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int slice_lsb(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/stream_demux_if.sv
// stream_demux_if: producer-side stream plus N consumer-side channels of the demux
interface stream_demux_if import demux_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_CH   = DEF_N_CH,
    parameter int CNT_W  = DEF_CNT_W
);
    localparam int SEL_W = sel_w(N_CH);
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_bcast;
    logic [N_CH-1:0]        out_valid;
    logic [N_CH-1:0]        out_ready;
    logic [N_CH*DATA_W-1:0] out_data;
    logic [CNT_W-1:0]       drop_cnt;
    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, drop_cnt
    );
    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, drop_cnt
    );
endinterface

// File: rtl/stream_demux_slot.sv
// stream_slot: one-entry register slice; a load wins over a simultaneous drain
module stream_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              slot_free
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next state: refill on load, otherwise empty once the consumer takes the word
    always_comb begin
        valid_d = load ? 1'b1 : (out_ready ? 1'b0 : valid_q);
        data_d  = load ? load_data : data_q;
    end

    // Slot registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign slot_free = !valid_q || out_ready;
endmodule

// File: rtl/stream_demux.sv
// stream_demux: 1-to-N handshaked demux with broadcast and saturating drop counter
module stream_demux import demux_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_CH   = DEF_N_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input logic           clk,
    input logic           rst_n,
    stream_demux_if.slave bus
);
    localparam int SEL_W = sel_w(N_CH);
    localparam int NS    = 1 << SEL_W;
    logic [N_CH-1:0]  slot_free, load;
    logic [NS-1:0]    free_ext;
    logic             sel_ok, in_fire, drop;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Pad slot_free to the full select range so out-of-range selects index safely
    assign free_ext    = NS'(slot_free);
    assign sel_ok      = {1'b0, bus.in_sel} < (SEL_W + 1)'(N_CH);
    assign bus.in_ready = rst_n && (bus.in_bcast ? &slot_free : (sel_ok ? free_ext[bus.in_sel] : 1'b1));
    assign in_fire     = bus.in_valid && bus.in_ready;
    assign drop        = in_fire && !bus.in_bcast && !sel_ok;
    assign bus.drop_cnt = cnt_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign load[k] = in_fire && (bus.in_bcast || bus.in_sel == SEL_W'(k));
        stream_slot #(.DATA_W(DATA_W)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (bus.in_data),
            .out_ready (bus.out_ready[k]),
            .out_valid (bus.out_valid[k]),
            .out_data  (bus.out_data[slice_lsb(k, DATA_W) +: DATA_W]),
            .slot_free (slot_free[k])
        );
    end

    // Drop counter advances once per discarded word and sticks at all-ones
    always_comb cnt_d = (drop && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    // Drop counter register
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed scenarios plus randomized run against a slot-occupancy model
module tb_stream_demux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stream_demux_if #(.DATA_W(8), .N_CH(4), .CNT_W(8)) b4();
    stream_demux_if #(.DATA_W(8), .N_CH(3), .CNT_W(2)) b3();

    stream_demux #(.DATA_W(8), .N_CH(4), .CNT_W(8)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    stream_demux #(.DATA_W(8), .N_CH(3), .CNT_W(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b4.in_valid = 1'b0; b4.in_data = '0; b4.in_sel = '0; b4.in_bcast = 1'b0; b4.out_ready = 4'hF;
        b3.in_valid = 1'b0; b3.in_data = '0; b3.in_sel = '0; b3.in_bcast = 1'b0; b3.out_ready = 3'h7;
    endtask

    task automatic send4(input logic [7:0] d, input logic [1:0] s, input logic bc);
        b4.in_valid = 1'b1; b4.in_data = d; b4.in_sel = s; b4.in_bcast = bc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) begin
            b4.in_valid = 1'($urandom); b4.in_data = 8'($urandom); b4.in_sel = 2'($urandom);
            b4.in_bcast = 1'($urandom); b4.out_ready = 4'($urandom);
            b3.in_valid = 1'($urandom); b3.in_data = 8'($urandom); b3.in_sel = 2'($urandom);
            b3.in_bcast = 1'($urandom); b3.out_ready = 3'($urandom);
            #1;
            vectors += 2;
            if (b4.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready4: got %b want 0", b4.in_ready); end
            if (b3.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready3: got %b want 0", b3.in_ready); end
            tick();
            vectors += 4;
            if (b4.out_valid !== 4'h0) begin errors++; $display("FAIL reset_out_valid: got %b want 0000", b4.out_valid); end
            if (b4.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", b4.out_data); end
            if (b4.drop_cnt !== 8'h0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", b4.drop_cnt); end
            if (b3.out_valid !== 3'h0) begin errors++; $display("FAIL reset_out_valid3: got %b want 000", b3.out_valid); end
        end
        idle();
        rst_n = 1'b1;
        #1;
        vectors++;
        if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", b4.in_ready); end
    endtask

    task automatic test_unicast();
        for (int i = 0; i < 4; i++) begin
            send4(8'hA0 + 8'(i), 2'(i), 1'b0);
            #1;
            vectors++;
            if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL uni_ready%0d: got %b want 1", i, b4.in_ready); end
            tick();
            vectors += 2;
            if (b4.out_valid !== 4'(1 << i)) begin errors++; $display("FAIL uni_valid%0d: got %b want %b", i, b4.out_valid, 4'(1 << i)); end
            if (b4.out_data[i*8 +: 8] !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL uni_data%0d: got %h want %h", i, b4.out_data[i*8 +: 8], 8'hA0 + 8'(i)); end
        end
        b4.in_valid = 1'b0;
        tick();
        vectors++;
        if (b4.out_valid !== 4'h0) begin errors++; $display("FAIL uni_drain: got %b want 0000", b4.out_valid); end
    endtask

    task automatic test_backpressure();
        b4.out_ready = 4'b1011;
        send4(8'h11, 2'd2, 1'b0);
        tick();
        send4(8'h22, 2'd2, 1'b0);
        repeat (3) begin
            #1;
            vectors += 3;
            if (b4.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", b4.in_ready); end
            if (b4.out_valid[2] !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", b4.out_valid[2]); end
            if (b4.out_data[23:16] !== 8'h11) begin errors++; $display("FAIL bp_hold: got %h want 11", b4.out_data[23:16]); end
            tick();
        end
        b4.out_ready = 4'hF;
        #1;
        vectors++;
        if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", b4.in_ready); end
        tick();
        vectors += 2;
        if (b4.out_valid !== 4'b0100) begin errors++; $display("FAIL bp_nobubble_valid: got %b want 0100", b4.out_valid); end
        if (b4.out_data[23:16] !== 8'h22) begin errors++; $display("FAIL bp_nobubble_data: got %h want 22", b4.out_data[23:16]); end
        b4.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_broadcast();
        b4.out_ready = 4'b1101;
        send4(8'h33, 2'd1, 1'b0);
        tick();
        send4(8'h5A, 2'd0, 1'b1);
        repeat (2) begin
            #1;
            vectors += 2;
            if (b4.in_ready !== 1'b0) begin errors++; $display("FAIL bc_ready: got %b want 0", b4.in_ready); end
            if (b4.out_valid !== 4'b0010) begin errors++; $display("FAIL bc_wait_valid: got %b want 0010", b4.out_valid); end
            tick();
        end
        b4.out_ready = 4'hF;
        #1;
        vectors++;
        if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL bc_release_ready: got %b want 1", b4.in_ready); end
        tick();
        vectors += 2;
        if (b4.out_valid !== 4'hF) begin errors++; $display("FAIL bc_valid: got %b want 1111", b4.out_valid); end
        if (b4.out_data !== 32'h5A5A5A5A) begin errors++; $display("FAIL bc_data: got %h want 5a5a5a5a", b4.out_data); end
        b4.in_valid = 1'b0;
        tick();
        vectors++;
        if (b4.out_valid !== 4'h0) begin errors++; $display("FAIL bc_drain: got %b want 0000", b4.out_valid); end
    endtask

    task automatic test_drop();
        b3.in_valid = 1'b1; b3.in_sel = 2'd3; b3.in_bcast = 1'b0; b3.in_data = 8'hEE;
        for (int i = 1; i <= 5; i++) begin
            #1;
            vectors++;
            if (b3.in_ready !== 1'b1) begin errors++; $display("FAIL drop_ready%0d: got %b want 1", i, b3.in_ready); end
            tick();
            vectors += 2;
            if (b3.out_valid !== 3'h0) begin errors++; $display("FAIL drop_valid%0d: got %b want 000", i, b3.out_valid); end
            if (b3.drop_cnt !== 2'(i < 3 ? i : 3)) begin errors++; $display("FAIL drop_cnt%0d: got %0d want %0d", i, b3.drop_cnt, (i < 3 ? i : 3)); end
        end
        b3.in_sel = 2'd2; b3.in_data = 8'h3C;
        tick();
        vectors += 2;
        if (b3.out_valid !== 3'b100) begin errors++; $display("FAIL n3_uni_valid: got %b want 100", b3.out_valid); end
        if (b3.out_data[23:16] !== 8'h3C) begin errors++; $display("FAIL n3_uni_data: got %h want 3c", b3.out_data[23:16]); end
        b3.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        b4.out_ready = 4'h0;
        send4(8'h77, 2'd0, 1'b0);
        tick();
        send4(8'h99, 2'd3, 1'b0);
        tick();
        vectors++;
        if (b4.out_valid !== 4'b1001) begin errors++; $display("FAIL mid_hold: got %b want 1001", b4.out_valid); end
        rst_n = 1'b0;
        b4.out_ready = 4'hF;
        send4(8'h44, 2'd1, 1'b0);
        #1;
        vectors++;
        if (b4.in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b want 0", b4.in_ready); end
        tick();
        vectors += 3;
        if (b4.out_valid !== 4'h0) begin errors++; $display("FAIL mid_valid: got %b want 0000", b4.out_valid); end
        if (b4.out_data !== 32'h0) begin errors++; $display("FAIL mid_data: got %h want 0", b4.out_data); end
        if (b3.drop_cnt !== 2'd0) begin errors++; $display("FAIL mid_drop_cnt: got %0d want 0", b3.drop_cnt); end
        rst_n = 1'b1;
        idle();
        repeat (3) begin
            tick();
            vectors++;
            if (b4.out_valid !== 4'h0) begin errors++; $display("FAIL mid_after: got %b want 0000", b4.out_valid); end
        end
    endtask

    task automatic test_random(input int n);
        logic [3:0] mv;
        logic [7:0] md [4];
        logic [3:0] free;
        logic       exp_rdy, fire;
        mv = '0;
        for (int k = 0; k < 4; k++) md[k] = '0;
        for (int c = 0; c < n; c++) begin
            b4.in_valid = 1'($urandom); b4.in_data = 8'($urandom); b4.in_sel = 2'($urandom);
            b4.in_bcast = ($urandom_range(7) == 0); b4.out_ready = 4'($urandom | $urandom);
            #1;
            free = ~mv | b4.out_ready;
            exp_rdy = b4.in_bcast ? (free == 4'hF) : free[b4.in_sel];
            vectors++;
            if (b4.in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, b4.in_ready, exp_rdy); end
            fire = b4.in_valid && exp_rdy;
            for (int k = 0; k < 4; k++) begin
                if (fire && (b4.in_bcast || b4.in_sel == 2'(k))) begin
                    mv[k] = 1'b1;
                    md[k] = b4.in_data;
                end else if (b4.out_ready[k]) begin
                    mv[k] = 1'b0;
                end
            end
            tick();
            vectors++;
            if (b4.out_valid !== mv) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, b4.out_valid, mv); end
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (b4.out_data[k*8 +: 8] !== md[k]) begin errors++; $display("FAIL rnd_data c%0d ch%0d: got %h want %h", c, k, b4.out_data[k*8 +: 8], md[k]); end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_unicast();
        test_backpressure();
        test_broadcast();
        test_drop();
        test_reset_mid();
        test_random(400);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised, handshaked 1-to-N stream demultiplexer, the registered successor to the combinational 1:4 demux. Each accepted input word is routed by a select field, or broadcast to all channels, into a one-entry output slot per channel with valid/ready flow control. It sits between a single producer and N independent consumers. Out-of-range selects are dropped and counted.

## Interface
- DATA_W, 8, payload width in bits (≥1)
- N_CH, 4, number of output channels (2..16, need not be a power of two)
- SEL_W, $clog2(N_CH), select width (derived, not overridden)
- CNT_W, 8, width of the drop counter
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input word present
- in_ready  out  1  block accepts the input word this cycle
- in_data  in  DATA_W  input payload
- in_sel  in  SEL_W  destination channel
- in_bcast  in  1  1 = deliver to every channel, in_sel ignored
- out_valid  out  N_CH  bit k = channel k slot holds a word
- out_ready  in  N_CH  bit k = consumer k takes the word
- out_data  out  N_CH*DATA_W  channel k payload at bits [k*DATA_W +: DATA_W]
- drop_cnt  out  CNT_W  count of dropped out-of-range words, saturating

## Operation
- Per channel k: slot_free[k] = !out_valid[k] || out_ready[k] (the slot empties this cycle or is already empty).
- Accept: in_fire = in_valid && in_ready.
- in_ready, combinational:
  - bcast: AND of all slot_free
  - sel < N_CH: slot_free[in_sel]
  - sel ≥ N_CH: 1, so the word is always consumed
  - forced 0 while rst_n = 0
- On in_fire, unicast: channel in_sel loads in_data and sets out_valid; other channels are unaffected.
- On in_fire, bcast: all channels load in_data and set out_valid in the same edge, so the broadcast is atomic.
- On in_fire with in_sel ≥ N_CH and !in_bcast: no channel is loaded. drop_cnt increments by 1 and saturates at 2^CNT_W−1.
- Per channel, every edge:
  - out_valid && out_ready && !load → out_valid clears
  - load → out_valid = 1, out_data = new word; this holds even when the old word drains on the same edge
- out_data is held stable while out_valid && !out_ready. A consumer stall never corrupts data.
- Channels drain independently. A stalled channel blocks only unicasts to itself and broadcasts.
- No ordering guarantee exists across channels. Within one channel, words leave in arrival order.

## Timing
- Latency: 1 cycle, in_fire at edge t → out_valid at t+1.
- Throughput: 1 word/cycle per channel with out_ready held high, and 1 word/cycle aggregate at the input.
- in_ready depends combinationally on out_ready, in_sel and in_bcast. It does not depend on in_valid.
- Reset, on the rst_n=0 edge: out_valid = 0, out_data = 0, drop_cnt = 0. in_ready is 0 throughout reset.
- Reset mid-operation: words held in slots are discarded. No output handshake completes on the reset edge.
- First accept is possible on the first edge with rst_n = 1.

## Structure
- demux_pkg holds:
  - default DATA_W, N_CH, CNT_W constants
  - the SEL_W derivation function
  - a helper for the out_data slice index
- Sub-module stream_slot (one-entry register slice) is instantiated N_CH times in a generate loop. Its ports: clk, rst_n, load, load_data, out_ready, out_valid, out_data, slot_free.
- The top level holds the in_ready decode, the load-enable decode and drop_cnt.

## Test plan
- Reset with all inputs random, then release → out_valid=0000, out_data=0, drop_cnt=0, in_ready=0 during reset.
- Unicast sweep with N_CH=4, out_ready=1111: send in_data=0xA0..0xA3, in_sel=0..3, one per cycle → each out_valid[k] pulses 1 cycle after its accept with out_data[k]=0xA0+k.
- Back-pressure: out_ready[2]=0, send 0x11 then 0x22 to channel 2 → 0x11 held stable, in_ready=0 for 0x22 until out_ready[2]=1. Then 0x22 loads on the same edge 0x11 drains, with no bubble.
- Broadcast with out_ready[1]=0 and slot 1 full: in_bcast=1, data 0x5A → in_ready=0 until slot 1 frees, then all 4 channels show 0x5A in the same cycle.
- Out-of-range with N_CH=3 (SEL_W=2): send in_sel=3 three times → in_ready=1, no out_valid, drop_cnt=3. With CNT_W=2, 5 drops → drop_cnt=3 (saturated).
- Reset asserted while channels 0 and 3 hold words → out_valid=0000 next cycle, and the words are not delivered after release.
